// File: rtl/cam_pkg.sv
// Shared camera-path types, state encoding and default OV7670-style VGA timing.
package cam_pkg;

  localparam int unsigned CAM_H_ACTIVE    = 640;
  localparam int unsigned CAM_V_ACTIVE    = 480;
  localparam int unsigned CAM_H_BLANK     = 288;
  localparam int unsigned CAM_VSYNC_LINES = 3;
  localparam int unsigned CAM_V_BACK      = 17;
  localparam int unsigned CAM_V_FRONT     = 10;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } dvp_tx_state_t;

  // Counter width able to hold 0..count-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cam_dvp_tx_if.sv
// Upstream RGB565 pixel handshake into the DVP transmitter.
interface cam_dvp_tx_if;
  import cam_pkg::*;

  rgb565_t pix_data;
  logic    pix_valid;
  logic    pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/dvp_timing_gen.sv
// Line/frame sequencer: hcnt/vcnt counters, frame state and the frame-end strobe.
// Next-position values are exported so the top can register outputs in step with the state.
module dvp_timing_gen
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = CAM_H_ACTIVE,
  parameter int unsigned H_BLANK     = CAM_H_BLANK,
  parameter int unsigned V_ACTIVE    = CAM_V_ACTIVE,
  parameter int unsigned VSYNC_LINES = CAM_VSYNC_LINES,
  parameter int unsigned V_BACK      = CAM_V_BACK,
  parameter int unsigned V_FRONT     = CAM_V_FRONT,
  localparam int unsigned LINE_LEN   = 2 * H_ACTIVE + H_BLANK,
  localparam int unsigned HW         = cnt_width(LINE_LEN)
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          enable,
  output dvp_tx_state_t state_nxt_c,
  output logic [HW-1:0] hcnt_nxt_c,
  output logic          frame_end
);

  localparam int unsigned VW = cnt_width(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT));

  dvp_tx_state_t state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [VW-1:0] vcnt, vcnt_n;
  logic          line_end;
  logic          last_line;

  assign line_end    = (hcnt == HW'(LINE_LEN - 1));
  assign state_nxt_c = state_n;
  assign hcnt_nxt_c  = hcnt_n;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      frame_end <= 1'b0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      vcnt      <= vcnt_n;
      frame_end <= (state_n == S_VFRONT) && (hcnt_n == HW'(LINE_LEN - 1)) &&
                   (vcnt_n == VW'(V_FRONT - 1));
    end
  end

  always_comb begin
    state_n   = state;
    hcnt_n    = '0;
    vcnt_n    = '0;
    last_line = 1'b0;

    unique case (state)
      S_VSYNC:  last_line = (vcnt == VW'(VSYNC_LINES - 1));
      S_VBACK:  last_line = (vcnt == VW'(V_BACK - 1));
      S_ACTIVE: last_line = (vcnt == VW'(V_ACTIVE - 1));
      S_VFRONT: last_line = (vcnt == VW'(V_FRONT - 1));
      default:  last_line = 1'b0;
    endcase

    if (state == S_IDLE) begin
      if (enable) state_n = S_VSYNC;
    end else begin
      hcnt_n = line_end ? '0 : hcnt + HW'(1);
      vcnt_n = vcnt;
      if (line_end) begin
        vcnt_n = last_line ? '0 : vcnt + VW'(1);
        if (last_line) begin
          unique case (state)
            S_VSYNC:  state_n = S_VBACK;
            S_VBACK:  state_n = S_ACTIVE;
            S_ACTIVE: state_n = S_VFRONT;
            S_VFRONT: state_n = enable ? S_VSYNC : S_IDLE;
            default:  state_n = S_IDLE;
          endcase
        end
      end
    end

    // Reset wins so next-position consumers (pix_ready, output registers) see idle.
    if (reset) begin
      state_n = S_IDLE;
      hcnt_n  = '0;
      vcnt_n  = '0;
    end
  end

endmodule

// File: rtl/cam_dvp_tx.sv
// OV7670-style DVP transmitter: serialises RGB565 pixels as high/low byte pairs under href/vsync.
module cam_dvp_tx
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = CAM_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = CAM_V_ACTIVE,
  parameter int unsigned H_BLANK     = CAM_H_BLANK,
  parameter int unsigned VSYNC_LINES = CAM_VSYNC_LINES,
  parameter int unsigned V_BACK      = CAM_V_BACK,
  parameter int unsigned V_FRONT     = CAM_V_FRONT
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               enable,
  cam_dvp_tx_if.slave        pix,
  output logic               href,
  output logic               vsync,
  output logic [7:0]         cam_data,
  output logic               frame_done,
  output logic               underflow
);

  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW        = cnt_width(LINE_LEN);
  localparam int unsigned ACT_BYTES = 2 * H_ACTIVE;

  dvp_tx_state_t state_nxt;
  logic [HW-1:0] hcnt_nxt;
  logic          href_nxt;
  logic          hi_slot_nxt;
  rgb565_t       pix_in;
  logic [7:0]    low_hold;

  dvp_timing_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_BLANK    (H_BLANK),
    .V_ACTIVE   (V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .pclk       (pclk),
    .reset      (reset),
    .enable     (enable),
    .state_nxt_c(state_nxt),
    .hcnt_nxt_c (hcnt_nxt),
    .frame_end  (frame_done)
  );

  // A pixel is requested in the cycle before its high-byte slot only.
  assign href_nxt      = (state_nxt == S_ACTIVE) && ({1'b0, hcnt_nxt} < (HW + 1)'(ACT_BYTES));
  assign hi_slot_nxt   = href_nxt && !hcnt_nxt[0];
  assign pix.pix_ready = hi_slot_nxt;
  assign pix_in        = pix.pix_valid ? pix.pix_data : rgb565_t'(0);

  always_ff @(posedge pclk) begin
    if (reset) begin
      href      <= 1'b0;
      vsync     <= 1'b0;
      cam_data  <= 8'h00;
      underflow <= 1'b0;
      low_hold  <= 8'h00;
    end else begin
      href  <= href_nxt;
      vsync <= (state_nxt == S_VSYNC);
      if (hi_slot_nxt) begin
        cam_data <= pix_in[15:8];
        low_hold <= pix_in[7:0];
        if (!pix.pix_valid) underflow <= 1'b1;
      end else begin
        cam_data <= href_nxt ? low_hold : 8'h00;
      end
    end
  end

endmodule
